// File: rtl/alu_share_arb.sv
// Two requesters share one 32-bit ALU. Grants alternate on contention, and
// each result is held until the consumer takes it.
module alu_share_arb (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_z,
    output logic        rsp_zero,
    output logic [15:0] ops_done
);

    // state | meaning
    // IDLE  | waiting for a request; grant is combinational
    // EXEC  | operands latched, ALU result registered on next edge
    // RESP  | result presented, held until rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nxt;
    logic        last_grant;
    logic        owner;
    logic [31:0] op_a, op_b;
    logic [2:0]  op_code;
    logic        grant;
    logic        accept;
    logic [31:0] alu_z;

    always_comb begin
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = req1_valid;
        if (state == IDLE && !reset) begin
            req0_ready = req0_valid && !grant;
            req1_ready = req1_valid && grant;
        end
        accept = req0_ready || req1_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_z = 32'd0;
        case (op_code)
            3'b000: alu_z = op_a & op_b;
            3'b001: alu_z = op_a | op_b;
            3'b010: alu_z = op_a + op_b;
            3'b110: alu_z = op_a - op_b;
            3'b111: alu_z = {31'd0, op_a < op_b};
            default: alu_z = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_z      <= 32'd0;
            rsp_zero   <= 1'b0;
            ops_done   <= 16'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            op_code    <= 3'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_a       <= grant ? req1_a  : req0_a;
                    op_b       <= grant ? req1_b  : req0_b;
                    op_code    <= grant ? req1_op : req0_op;
                    owner      <= grant;
                    last_grant <= grant;
                end
                EXEC: begin
                    rsp_z     <= alu_z;
                    rsp_zero  <= (alu_z == 32'd0);
                    rsp_id    <= owner;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    ops_done  <= ops_done + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: contention, fairness, back-pressure,
// op sweep and reset abort, each with hand-computed expected values.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_z;
    logic [15:0] ops_done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ops = 0;

    alu_share_arb dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_z(rsp_z), .rsp_zero(rsp_zero), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int cnt = 0;
        while (!rsp_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_ops++;
        check({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ops_done"}, 32'(ops_done), 32'(exp_ops[15:0]));
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] exp_z, input string tag);
        int   cnt = 0;
        logic rdy;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        #1;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
            rdy = id ? req1_ready : req0_ready;
        end
        check({tag, "_ready"}, 32'(rdy), 32'd1);
        @(posedge clk); #1;
        // operands change after acceptance; result must not follow
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req1_a = ~a; req0_b = ~b; req1_b = ~b;
        check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_lat_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_z"}, rsp_z, exp_z);
        check({tag, "_zero"}, 32'(rsp_zero), 32'(exp_z == 32'd0));
        check({tag, "_id"}, 32'(rsp_id), 32'(id));
        handshake(tag);
        check({tag, "_z_hold"}, rsp_z, exp_z);
    endtask

    task automatic serve_both(input int n, input logic first_id, input string tag);
        logic exp_id;
        for (int i = 0; i < n; i++) begin
            exp_id = first_id ^ i[0];
            wait_rsp(tag);
            check({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
            check({tag, "_z"}, rsp_z, exp_id ? 32'd1 : 32'd0);
            check({tag, "_zero"}, 32'(rsp_zero), exp_id ? 32'd0 : 32'd1);
            handshake(tag);
        end
    endtask

    logic [2:0]  sweep_op [6] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011};
    logic [31:0] sweep_z  [6] = '{32'h00F000F0, 32'hFFF0FFF0, 32'h00E100E0,
                                  32'hE100E100, 32'h0, 32'h0};

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h1234ABCD; req0_b = 32'h1234ABCD; req0_op = 3'b110;
        req1_a = 32'd1;        req1_b = 32'd2;        req1_op = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_z", rsp_z, 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        reset = 1'b0;

        // contention after reset, then continuous fairness
        serve_both(2, 1'b0, "contend");
        check("contend_ops2", 32'(ops_done), 32'd2);
        serve_both(6, 1'b0, "fair");
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 32'h5, 32'h3, 3'b010, 32'h8, "add");

        // back-pressure: result held, requesters blocked
        req1_a = 32'd1; req1_b = 32'd2; req1_op = 3'b001; req1_valid = 1'b1;
        wait_rsp("bp");
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_z", rsp_z, 32'd3);
            check("bp_id", 32'(rsp_id), 32'd1);
            check("bp_zero", 32'(rsp_zero), 32'd0);
            check("bp_req0_ready", 32'(req0_ready), 32'd0);
            check("bp_req1_ready", 32'(req1_ready), 32'd0);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        handshake("bp");
        check("bp_z_hold", rsp_z, 32'd3);

        for (int i = 0; i < 6; i++)
            run_op(1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, sweep_op[i], sweep_z[i], "sweep");

        // reset while a response is pending
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ops = 0;
        req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b010; req0_valid = 1'b1;
        wait_rsp("abort");
        req1_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_valid", 32'(rsp_valid), 32'd0);
        check("abort_ops_done", 32'(ops_done), 32'd0);
        check("abort_req0_ready", 32'(req0_ready), 32'd1);
        check("abort_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp("post_abort");
        check("post_abort_id", 32'(rsp_id), 32'd0);
        check("post_abort_z", rsp_z, 32'd2);
        handshake("post_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
